// File: rtl/hyperbus_ck_sequencer_if.sv
// Handshake and CK/CS# control bundle between the HyperBus transaction FSM
// (master) and the CK/CS# sequencer (slave).
interface hyperbus_ck_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             req_i;
  logic [CNT_W-1:0] len_i;
  logic             stop_i;
  logic             gnt_o;
  logic             cs_no;
  logic             ck_en_o;
  logic [CNT_W-1:0] ck_cnt_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output req_i, len_i, stop_i,
    input  gnt_o, cs_no, ck_en_o, ck_cnt_o, busy_o, done_o
  );

  modport slave (
    input  req_i, len_i, stop_i,
    output gnt_o, cs_no, ck_en_o, ck_cnt_o, busy_o, done_o
  );
endinterface

// File: rtl/hyperbus_ck_sequencer.sv
// HyperBus CK/CS# sequencer: frames each granted transaction with CS# setup,
// a run of exactly len CK-enable cycles (or fewer on stop), CS# hold and a
// minimum CS# high recovery time. Sole owner of the CK gating enable.
module hyperbus_ck_sequencer #(
  parameter int CNT_W    = 16,
  parameter int CSS_CYC  = 2,
  parameter int CSH_CYC  = 2,
  parameter int CSHI_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hyperbus_ck_sequencer_if.slave bus
);

  // One shared phase counter covers setup, hold and recovery.
  localparam int PH_MAX = (CSS_CYC > CSH_CYC) ?
                          ((CSS_CYC > CSHI_CYC) ? CSS_CYC : CSHI_CYC) :
                          ((CSH_CYC > CSHI_CYC) ? CSH_CYC : CSHI_CYC);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] CSS_LD  = PH_W'(CSS_CYC - 1);
  localparam logic [PH_W-1:0] CSH_LD  = PH_W'(CSH_CYC - 1);
  localparam logic [PH_W-1:0] CSHI_LD = PH_W'(CSHI_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RUN     = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             cs_n_q, cs_n_d;
  logic             ck_en_q, ck_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gnt;
  logic             ph_zero;
  logic             len_last;

  assign gnt      = bus.req_i && (state_q == IDLE);
  assign ph_zero  = (ph_q == '0);
  // Length 0 or 1 both mean "this is the final RUN cycle".
  assign len_last = (len_q[CNT_W-1:1] == '0);

  // Next-state, counter and output decode. Outputs are computed from the
  // next state so the registered versions are glitch-free levels.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = SETUP;
          ph_d    = CSS_LD;
          len_d   = bus.len_i;
        end
      end
      SETUP: begin
        if (ph_zero) begin
          if (len_q != '0) begin
            state_d = RUN;
          end else begin
            state_d = HOLD;
            ph_d    = CSH_LD;
          end
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      RUN: begin
        // Saturating decrement: the counter never wraps below zero.
        if (len_q != '0) len_d = len_q - 1'b1;
        if (len_last || bus.stop_i) begin
          state_d = HOLD;
          ph_d    = CSH_LD;
        end
      end
      HOLD: begin
        if (ph_zero) begin
          state_d = RECOVER;
          ph_d    = CSHI_LD;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      RECOVER: begin
        if (ph_zero) begin
          state_d = IDLE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ph_d    = '0;
      end
    endcase

    cs_n_d  = (state_d == IDLE) || (state_d == RECOVER);
    ck_en_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    // Pulse on the final RECOVER cycle, i.e. when RECOVER is entered or
    // continued with the phase counter reaching zero.
    done_d  = (state_d == RECOVER) && (ph_d == '0);
  end

  // State, counters and registered outputs; async reset forces CS# high and
  // CK disabled immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ph_q    <= '0;
      len_q   <= '0;
      cs_n_q  <= 1'b1;
      ck_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      len_q   <= len_d;
      cs_n_q  <= cs_n_d;
      ck_en_q <= ck_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.cs_no    = cs_n_q;
  assign bus.ck_en_o  = ck_en_q;
  assign bus.ck_cnt_o = len_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule
